// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage sitting directly after the ALU.
// Handles one instruction at a time. Loads and stores run one req/ack bus
// transaction and hold oReady low until the ack arrives. Non-memory results
// retire one registered cycle after acceptance. Illegal accesses (and, when
// LSU_MISALIGN_TRAP_EN is defined, misaligned ones) raise a one-cycle
// exception pulse instead of touching the bus.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  - defined: misaligned half/word accesses trap with
//                           cause 01. Undefined: the low address bits below
//                           the access size are cleared and the access proceeds.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    output logic            oReady,
    input  logic            iIsLoad,
    input  logic            iIsStore,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iAddr,
    input  logic [XLEN-1:0] iStoreData,
    input  logic [XLEN-1:0] iAluResult,
    input  logic [4:0]      iRd,
    input  logic            iRegWr,
    output logic            oMemReq,
    output logic            oMemWe,
    output logic [XLEN-1:0] oMemAddr,
    output logic [XLEN-1:0] oMemWdata,
    output logic [3:0]      oMemBe,
    input  logic            iMemAck,
    input  logic [XLEN-1:0] iMemRdata,
    output logic            oWbValid,
    output logic [4:0]      oWbRd,
    output logic [XLEN-1:0] oWbData,
    output logic            oWbRegWr,
    output logic            oExcValid,
    output logic [1:0]      oExcCause,
    output logic [XLEN-1:0] oExcAddr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

    // Pick the addressed lane out of the read word and extend it per funct3.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  lane,
        input logic [31:0] word
    );
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        shifted = word >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_extract = {{16{half_v[15]}}, half_v};
            3'b100:  load_extract = {24'h000000, byte_v};
            3'b101:  load_extract = {16'h0000, half_v};
            default: load_extract = word;
        endcase
    endfunction

    logic [0:0]      state_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [XLEN-1:0] mem_addr_r;
    logic [XLEN-1:0] mem_wdata_r;
    logic [3:0]      mem_be_r;
    logic [4:0]      pend_rd_r;
    logic            pend_regwr_r;
    logic            pend_load_r;
    logic [2:0]      pend_f3_r;
    logic [1:0]      pend_lane_r;
    logic            wb_valid_r;
    logic [4:0]      wb_rd_r;
    logic [XLEN-1:0] wb_data_r;
    logic            wb_regwr_r;
    logic            exc_valid_r;
    logic [1:0]      exc_cause_r;
    logic [XLEN-1:0] exc_addr_r;

    logic            accept_s;
    logic            is_mem_s;
    logic            illegal_s;
    logic            misalign_s;
    logic            misalign_trap_s;
    logic [1:0]      lane_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s;

    assign oReady   = (state_r == IDLE);
    assign accept_s = iValid && oReady;
    assign is_mem_s = iIsLoad || iIsStore;

    // Classify the incoming access: illegal encoding and misalignment.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (iIsLoad && iIsStore) begin
            illegal_s = 1'b1;
        end else if (iIsLoad) begin
            illegal_s = (iFunct3 == 3'b011) || (iFunct3 == 3'b110) ||
                        (iFunct3 == 3'b111);
        end else if (iIsStore) begin
            illegal_s = (iFunct3 >= 3'b011);
        end else begin
            illegal_s = 1'b0;
        end
        case (iFunct3[1:0])
            2'b01:   misalign_s = iAddr[0];
            2'b10:   misalign_s = (iAddr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap_s = misalign_s;
`else
    assign misalign_trap_s = 1'b0;
`endif

    // Lane and store formatting; low bits below the access size are cleared
    // so an untrapped misaligned access lands on its natural boundary.
    always_comb begin
        lane_s  = iAddr[1:0];
        be_s    = 4'b1111;
        wdata_s = iStoreData;
        case (iFunct3[1:0])
            2'b00: begin
                lane_s  = iAddr[1:0];
                be_s    = 4'b0001 << iAddr[1:0];
                wdata_s = {4{iStoreData[7:0]}};
            end
            2'b01: begin
                lane_s  = {iAddr[1], 1'b0};
                be_s    = iAddr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{iStoreData[15:0]}};
            end
            default: begin
                lane_s  = 2'b00;
                be_s    = 4'b1111;
                wdata_s = iStoreData;
            end
        endcase
        if (iIsLoad) begin
            be_s    = 4'b1111;
            wdata_s = {XLEN{1'b0}};
        end else begin
            be_s    = be_s;
            wdata_s = wdata_s;
        end
    end

    // Control FSM, bus request registers and writeback/exception pulses.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_r      <= IDLE;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {XLEN{1'b0}};
            mem_wdata_r  <= {XLEN{1'b0}};
            mem_be_r     <= 4'b0000;
            pend_rd_r    <= 5'd0;
            pend_regwr_r <= 1'b0;
            pend_load_r  <= 1'b0;
            pend_f3_r    <= 3'b000;
            pend_lane_r  <= 2'b00;
            wb_valid_r   <= 1'b0;
            wb_rd_r      <= 5'd0;
            wb_data_r    <= {XLEN{1'b0}};
            wb_regwr_r   <= 1'b0;
            exc_valid_r  <= 1'b0;
            exc_cause_r  <= 2'b00;
            exc_addr_r   <= {XLEN{1'b0}};
        end else begin
            wb_valid_r  <= 1'b0;
            exc_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (!is_mem_s) begin
                            wb_valid_r <= 1'b1;
                            wb_rd_r    <= iRd;
                            wb_data_r  <= iAluResult;
                            wb_regwr_r <= iRegWr && (iRd != 5'd0);
                        end else if (illegal_s) begin
                            exc_valid_r <= 1'b1;
                            exc_cause_r <= CAUSE_ILLEGAL;
                            exc_addr_r  <= iAddr;
                        end else if (misalign_trap_s) begin
                            exc_valid_r <= 1'b1;
                            exc_cause_r <= CAUSE_MISALIGN;
                            exc_addr_r  <= iAddr;
                        end else begin
                            mem_req_r    <= 1'b1;
                            mem_we_r     <= iIsStore;
                            mem_addr_r   <= {iAddr[XLEN-1:2], 2'b00};
                            mem_wdata_r  <= wdata_s;
                            mem_be_r     <= be_s;
                            pend_rd_r    <= iRd;
                            pend_regwr_r <= iIsLoad && iRegWr && (iRd != 5'd0);
                            pend_load_r  <= iIsLoad;
                            pend_f3_r    <= iFunct3;
                            pend_lane_r  <= lane_s;
                            state_r      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (iMemAck) begin
                        mem_req_r  <= 1'b0;
                        wb_valid_r <= 1'b1;
                        wb_rd_r    <= pend_rd_r;
                        wb_data_r  <= pend_load_r ?
                                      load_extract(pend_f3_r, pend_lane_r, iMemRdata) :
                                      {XLEN{1'b0}};
                        wb_regwr_r <= pend_regwr_r;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign oMemReq   = mem_req_r;
    assign oMemWe    = mem_we_r;
    assign oMemAddr  = mem_addr_r;
    assign oMemWdata = mem_wdata_r;
    assign oMemBe    = mem_be_r;
    assign oWbValid  = wb_valid_r;
    assign oWbRd     = wb_rd_r;
    assign oWbData   = wb_data_r;
    assign oWbRegWr  = wb_regwr_r;
    assign oExcValid = exc_valid_r;
    assign oExcCause = exc_cause_r;
    assign oExcAddr  = exc_addr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the stimulus thread pushes expected
// writeback/exception records and bus transactions; a monitor pops and
// compares retire pulses, and a bus responder checks requests and acks them.
module tb_load_store_unit;

    typedef struct {
        logic        is_exc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        regwr;
        logic        chk;
        logic [1:0]  cause;
        logic [31:0] addr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
        logic [31:0] rdata;
        int          delay;
    } bus_t;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic        iIsLoad;
    logic        iIsStore;
    logic [2:0]  iFunct3;
    logic [31:0] iAddr;
    logic [31:0] iStoreData;
    logic [31:0] iAluResult;
    logic [4:0]  iRd;
    logic        iRegWr;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWdata;
    logic [3:0]  oMemBe;
    logic        iMemAck;
    logic [31:0] iMemRdata;
    logic        oWbValid;
    logic [4:0]  oWbRd;
    logic [31:0] oWbData;
    logic        oWbRegWr;
    logic        oExcValid;
    logic [1:0]  oExcCause;
    logic [31:0] oExcAddr;

    int   errors = 0;
    int   checks = 0;
    int   wb_seen = 0;
    exp_t exp_q[$];
    bus_t bus_q[$];
    exp_t mon_e;
    bus_t cur;
    int   cnt = 0;
    logic in_txn = 1'b0;
    logic bus_en = 1'b1;
    logic stray_ack = 1'b0;
    logic ack_now;

    load_store_unit #(.XLEN(32)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iIsLoad(iIsLoad), .iIsStore(iIsStore), .iFunct3(iFunct3),
        .iAddr(iAddr), .iStoreData(iStoreData), .iAluResult(iAluResult),
        .iRd(iRd), .iRegWr(iRegWr), .oMemReq(oMemReq), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemWdata(oMemWdata), .oMemBe(oMemBe),
        .iMemAck(iMemAck), .iMemRdata(iMemRdata), .oWbValid(oWbValid),
        .oWbRd(oWbRd), .oWbData(oWbData), .oWbRegWr(oWbRegWr),
        .oExcValid(oExcValid), .oExcCause(oExcCause), .oExcAddr(oExcAddr)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data,
                           input logic regwr, input logic chkd);
        exp_t e;
        e.is_exc = 1'b0; e.rd = rd; e.data = data; e.regwr = regwr;
        e.chk = chkd; e.cause = 2'b00; e.addr = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_exc(input logic [1:0] cause, input logic [31:0] addr);
        exp_t e;
        e.is_exc = 1'b1; e.rd = 5'd0; e.data = 32'h0; e.regwr = 1'b0;
        e.chk = 1'b0; e.cause = cause; e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic chk_wd,
                            input logic [31:0] rdata, input int delay);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        b.chk_wd = chk_wd; b.rdata = rdata; b.delay = delay;
        bus_q.push_back(b);
    endtask

    // Present one instruction; caller is aligned one unit after a rising edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        int n;
        n = 0;
        while (!oReady && n < 50) begin
            @(posedge iClk); #1;
            n++;
        end
        if (!oReady) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout: oReady=%b expected 1", oReady);
        end
        iValid = 1'b1; iIsLoad = ld; iIsStore = st; iFunct3 = f3; iAddr = addr;
        iStoreData = sd; iAluResult = alu; iRd = rd; iRegWr = rw;
        @(posedge iClk); #1;
        iValid = 1'b0; iIsLoad = 1'b0; iIsStore = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0 || in_txn) && n < 100) begin
            @(posedge iClk); #1;
            n++;
        end
        chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
        chk("drain_bus_q", 32'(bus_q.size()), 32'd0);
    endtask

    // Monitor: pop one expected record per retire or exception pulse.
    always @(negedge iClk) begin
        if (oWbValid || oExcValid) begin
            chk("wb_exc_exclusive", 32'(oWbValid & oExcValid), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: wb=%b exc=%b expected none", oWbValid, oExcValid);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_kind_exc", 32'(oExcValid), 32'(mon_e.is_exc));
                if (mon_e.is_exc) begin
                    chk("exc_cause", 32'(oExcCause), 32'(mon_e.cause));
                    chk("exc_addr", oExcAddr, mon_e.addr);
                end else begin
                    chk("wb_regwr", 32'(oWbRegWr), 32'(mon_e.regwr));
                    if (mon_e.chk) begin
                        chk("wb_rd", 32'(oWbRd), 32'(mon_e.rd));
                        chk("wb_data", oWbData, mon_e.data);
                    end
                end
            end
        end
        if (oWbValid) wb_seen++;
    end

    // Bus responder: check each request against the expected transaction, ack after its delay.
    initial begin
        iMemAck = 1'b0;
        iMemRdata = 32'h0;
        forever begin
            @(posedge iClk); #1;
            ack_now = 1'b0;
            if (bus_en && oMemReq) begin
                if (!in_txn) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: oMemReq=%b addr=%h expected no request", oMemReq, oMemAddr);
                    end else begin
                        cur = bus_q.pop_front();
                        in_txn = 1'b1;
                        cnt = 0;
                    end
                end
                if (in_txn) begin
                    chk("mem_addr", oMemAddr, cur.addr);
                    chk("mem_we", 32'(oMemWe), 32'(cur.we));
                    chk("mem_be", 32'(oMemBe), 32'(cur.be));
                    if (cur.chk_wd) chk("mem_wdata", oMemWdata, cur.wdata);
                    chk("ready_low_in_wait", 32'(oReady), 32'd0);
                    if (cnt == cur.delay) begin
                        ack_now = 1'b1;
                        iMemRdata = cur.rdata;
                        in_txn = 1'b0;
                    end else begin
                        cnt++;
                    end
                end
            end
            iMemAck = ack_now | stray_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb_before;
        iRst = 1'b0; iValid = 1'b0; iIsLoad = 1'b0; iIsStore = 1'b0; iFunct3 = 3'b000;
        iAddr = 32'h0; iStoreData = 32'h0; iAluResult = 32'h0; iRd = 5'd0; iRegWr = 1'b0;
        #12;
        chk("rst_memreq", 32'(oMemReq), 32'd0);
        chk("rst_wbvalid", 32'(oWbValid), 32'd0);
        chk("rst_excvalid", 32'(oExcValid), 32'd0);
        chk("rst_wbdata", oWbData, 32'd0);
        chk("rst_memaddr", oMemAddr, 32'd0);
        chk("rst_ready", 32'(oReady), 32'd1);
        @(negedge iClk); iRst = 1'b1;
        @(posedge iClk); #1;

        // Non-memory pass-through, back to back, plus rd=0.
        push_wb(5'd5, 32'h00001234, 1'b1, 1'b1);
        push_wb(5'd5, 32'h00001234, 1'b1, 1'b1);
        push_wb(5'd5, 32'h00001234, 1'b1, 1'b1);
        push_wb(5'd0, 32'h0000ABCD, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00001234, 5'd5, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00001234, 5'd5, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00001234, 5'd5, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000ABCD, 5'd0, 1'b1);
        drain();

        // Byte loads with sign/zero extension.
        push_bus(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0, 32'h80000000, 2);
        push_wb(5'd7, 32'hFFFFFF80, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b000, 32'h00001003, 32'h0, 32'h0, 5'd7, 1'b1);
        push_bus(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0, 32'h80000000, 2);
        push_wb(5'd7, 32'h00000080, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b100, 32'h00001003, 32'h0, 32'h0, 5'd7, 1'b1);
        push_bus(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0, 32'h00007F00, 0);
        push_wb(5'd8, 32'h0000007F, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b000, 32'h00001001, 32'h0, 32'h0, 5'd8, 1'b1);

        // Halfword loads.
        push_bus(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0, 32'h80017FFF, 1);
        push_wb(5'd9, 32'hFFFF8001, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b001, 32'h00001002, 32'h0, 32'h0, 5'd9, 1'b1);
        push_bus(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0, 32'h80017FFF, 0);
        push_wb(5'd9, 32'h00008001, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b101, 32'h00001002, 32'h0, 32'h0, 5'd9, 1'b1);

        // Stores: SH, SB, SW.
        push_bus(1'b1, 32'h00002000, 4'b1100, 32'hCCDDCCDD, 1'b1, 32'h0, 0);
        push_wb(5'd3, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 32'h00002002, 32'hAABBCCDD, 32'h0, 5'd3, 1'b1);
        push_bus(1'b1, 32'h00002000, 4'b0010, 32'h44444444, 1'b1, 32'h0, 1);
        push_wb(5'd3, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b000, 32'h00002001, 32'h11223344, 32'h0, 5'd3, 1'b1);
        push_bus(1'b1, 32'h00002004, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0, 0);
        push_wb(5'd3, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h00002004, 32'hCAFEF00D, 32'h0, 5'd3, 1'b1);

        // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
        push_exc(2'b01, 32'h00003001);
        issue(1'b1, 1'b0, 3'b010, 32'h00003001, 32'h0, 32'h0, 5'd4, 1'b1);
        push_exc(2'b01, 32'h00001003);
        issue(1'b1, 1'b0, 3'b001, 32'h00001003, 32'h0, 32'h0, 5'd4, 1'b1);
        push_exc(2'b01, 32'h00002006);
        issue(1'b0, 1'b1, 3'b010, 32'h00002006, 32'h01020304, 32'h0, 5'd4, 1'b1);
`else
        push_bus(1'b0, 32'h00003000, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1);
        push_wb(5'd4, 32'hDEADBEEF, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h00003001, 32'h0, 32'h0, 5'd4, 1'b1);
        push_bus(1'b0, 32'h00001000, 4'b1111, 32'h0, 1'b0, 32'h80017FFF, 0);
        push_wb(5'd4, 32'hFFFF8001, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 3'b001, 32'h00001003, 32'h0, 32'h0, 5'd4, 1'b1);
        push_bus(1'b1, 32'h00002004, 4'b1111, 32'h01020304, 1'b1, 32'h0, 0);
        push_wb(5'd4, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b010, 32'h00002006, 32'h01020304, 32'h0, 5'd4, 1'b1);
`endif

        // Illegal encodings (illegal wins over misaligned).
        push_exc(2'b10, 32'h00005000);
        issue(1'b1, 1'b0, 3'b011, 32'h00005000, 32'h0, 32'h0, 5'd6, 1'b1);
        push_exc(2'b10, 32'h00005001);
        issue(1'b1, 1'b0, 3'b110, 32'h00005001, 32'h0, 32'h0, 5'd6, 1'b1);
        push_exc(2'b10, 32'h00005004);
        issue(1'b0, 1'b1, 3'b011, 32'h00005004, 32'h0, 32'h0, 5'd6, 1'b1);
        push_exc(2'b10, 32'h00007000);
        issue(1'b1, 1'b1, 3'b010, 32'h00007000, 32'h0, 32'h0, 5'd6, 1'b1);

        // Load to x0 never writes.
        push_bus(1'b0, 32'h00006000, 4'b1111, 32'h0, 1'b0, 32'h12345678, 0);
        push_wb(5'd0, 32'h12345678, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h00006000, 32'h0, 32'h0, 5'd0, 1'b1);
        drain();

        // Reset in the middle of WAIT; a stray ack afterwards is ignored.
        bus_en = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h00004000, 32'h0, 32'h0, 5'd9, 1'b1);
        chk("req_before_reset", 32'(oMemReq), 32'd1);
        #2 iRst = 1'b0;
        #1;
        chk("midrst_memreq", 32'(oMemReq), 32'd0);
        chk("midrst_memaddr", oMemAddr, 32'd0);
        chk("midrst_membe", 32'(oMemBe), 32'd0);
        chk("midrst_wbvalid", 32'(oWbValid), 32'd0);
        chk("midrst_excvalid", 32'(oExcValid), 32'd0);
        chk("midrst_ready", 32'(oReady), 32'd1);
        @(negedge iClk);
        @(negedge iClk); iRst = 1'b1;
        wb_before = wb_seen;
        @(negedge iClk); stray_ack = 1'b1;
        @(negedge iClk); stray_ack = 1'b0;
        repeat (3) @(negedge iClk);
        chk("stray_ack_no_wb", 32'(wb_seen - wb_before), 32'd0);
        chk("stray_ack_no_req", 32'(oMemReq), 32'd0);
        @(posedge iClk); #1;
        bus_en = 1'b1;

        // Normal operation resumes after the reset.
        push_wb(5'd2, 32'h00000042, 1'b1, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00000042, 5'd2, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
